// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared lamp encodings and phase-state enum for the traffic
//               light controllers (N-phase and legacy 2-road).
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    // Per-phase lamp encodings as driven onto the lamp driver bus
    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    // Right-of-way sequence for the phase currently being served
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_state_t;

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/tlc_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : tlc_rr_select
// Description : Combinational round-robin search. Returns the first pending
//               phase after active_phase_i, wrapping, with active_phase_i
//               itself examined last.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_rr_select #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = 2
) (
    input  logic [NUM_PHASES-1:0] pending_i,
    input  logic [PH_W-1:0]       active_phase_i,
    output logic [PH_W-1:0]       next_phase_o,
    output logic                  any_valid_o
);

    // Scan from the farthest offset down so the nearest pending phase wins
    always_comb begin
        next_phase_o = active_phase_i;
        any_valid_o  = 1'b0;
        for (int i = NUM_PHASES; i >= 1; i--) begin
            if (pending_i[(32'(active_phase_i) + 32'(i)) % NUM_PHASES]) begin
                next_phase_o = PH_W'((32'(active_phase_i) + 32'(i)) % NUM_PHASES);
                any_valid_o  = 1'b1;
            end
        end
    end

endmodule : tlc_rr_select
`default_nettype wire

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_controller
// Description : N-phase demand-actuated intersection controller. Serves the
//               approaches round-robin with min/max green, fixed yellow and
//               all-red clearance; all timing advances on the tick enable.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES   = 4,
    parameter int CNT_W        = 8,
    parameter int MIN_GREEN    = 10,
    parameter int MAX_GREEN    = 60,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic [NUM_PHASES-1:0]         demand,
    output logic [2*NUM_PHASES-1:0]       lights,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          phase_start,
    output logic [NUM_PHASES-1:0]         pending
);

    localparam int PH_W = $clog2(NUM_PHASES);

    // Timer compare points; the timer holds completed ticks, hence the -1
    localparam logic [CNT_W-1:0] MIN_G_M1  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_G_M1  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    // Phase 0 green, every other approach red
    localparam logic [2*NUM_PHASES-1:0] LIGHTS_RST =
        {{(NUM_PHASES-1){LIGHT_RED}}, LIGHT_GREEN};

    // Reject illegal parameter sets at elaboration
    if (NUM_PHASES < 2) begin : g_chk_phases
        $error("NUM_PHASES must be >= 2");
    end
    if (MIN_GREEN < 1) begin : g_chk_min_green
        $error("MIN_GREEN must be >= 1");
    end
    if (MAX_GREEN < MIN_GREEN) begin : g_chk_max_green
        $error("MAX_GREEN must be >= MIN_GREEN");
    end
    if (YELLOW_TIME < 1) begin : g_chk_yellow
        $error("YELLOW_TIME must be >= 1");
    end
    if (ALL_RED_TIME < 1) begin : g_chk_all_red
        $error("ALL_RED_TIME must be >= 1");
    end
    if (MAX_GREEN > (2**CNT_W) - 1) begin : g_chk_cnt_w
        $error("CNT_W too narrow to hold MAX_GREEN");
    end

    phase_state_t              state_q, state_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic [CNT_W-1:0]          timer_q, timer_d;
    logic [NUM_PHASES-1:0]     pending_q, pending_d;
    logic                      start_q, start_d;
    logic [2*NUM_PHASES-1:0]   lights_q, lights_d;

    logic [NUM_PHASES-1:0]     w_active_oh;
    logic [NUM_PHASES-1:0]     w_pend_set;
    logic                      w_other_req;
    logic [PH_W-1:0]           w_rr_next;
    logic                      w_rr_valid;
    logic [CNT_W-1:0]          w_timer_inc;

    tlc_rr_select #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_rr_select (
        .pending_i      (pending_q),
        .active_phase_i (phase_q),
        .next_phase_o   (w_rr_next),
        .any_valid_o    (w_rr_valid)
    );

    // Request bookkeeping: the green phase cannot latch its own demand
    always_comb begin
        w_active_oh          = '0;
        w_active_oh[phase_q] = 1'b1;
        w_other_req          = |(pending_q & ~w_active_oh);
        w_pend_set           = demand;
        if (state_q == PH_GREEN) begin
            w_pend_set = demand & ~w_active_oh;
        end
        w_timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    end

    // Next-state logic; nothing but request latching moves without a tick
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        timer_d   = timer_q;
        start_d   = 1'b0;
        pending_d = pending_q | w_pend_set;
        if (tick) begin
            case (state_q)
                PH_GREEN: begin
                    if ((timer_q >= MIN_G_M1) && w_other_req &&
                        (!demand[phase_q] || (timer_q >= MAX_G_M1))) begin
                        state_d = PH_YELLOW;
                        timer_d = '0;
                    end else begin
                        timer_d = w_timer_inc;
                    end
                end
                PH_YELLOW: begin
                    if (timer_q == YEL_M1) begin
                        state_d = PH_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = w_timer_inc;
                    end
                end
                PH_ALLRED: begin
                    if (timer_q == AR_M1) begin
                        state_d            = PH_GREEN;
                        timer_d            = '0;
                        phase_d            = w_rr_valid ? w_rr_next : phase_q;
                        start_d            = 1'b1;
                        // Entering green serves the request, clear beats set
                        pending_d[phase_d] = 1'b0;
                    end else begin
                        timer_d = w_timer_inc;
                    end
                end
                default: begin
                    state_d = PH_GREEN;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Lamp decode of the next state so the lamps register with the state
    always_comb begin
        lights_d = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (PH_W'(p) == phase_d) begin
                case (state_d)
                    PH_GREEN:  lights_d[2*p +: 2] = LIGHT_GREEN;
                    PH_YELLOW: lights_d[2*p +: 2] = LIGHT_YELLOW;
                    default:   lights_d[2*p +: 2] = LIGHT_RED;
                endcase
            end else begin
                lights_d[2*p +: 2] = LIGHT_RED;
            end
        end
    end

    // Phase FSM, timer, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PH_GREEN;
            phase_q   <= '0;
            timer_q   <= '0;
            pending_q <= '0;
            start_q   <= 1'b0;
            lights_q  <= LIGHTS_RST;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            start_q   <= start_d;
            lights_q  <= lights_d;
        end
    end

    assign lights       = lights_q;
    assign active_phase = phase_q;
    assign phase_start  = start_q;
    assign pending      = pending_q;

endmodule : traffic_phase_controller
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_controller
// Description : Directed bench for traffic_phase_controller (default params).
//               Expected green starts go into a scoreboard queue; a monitor
//               pops one on every phase_start pulse and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b1;
    logic [3:0] demand = 4'h0;
    logic [7:0] lights;
    logic [1:0] active_phase;
    logic       phase_start;
    logic [3:0] pending;

    typedef struct {
        int         edge_no;
        logic [1:0] ph;
        logic [7:0] lt;
        logic [3:0] pd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   base = 0;
    bit   tick_div = 1'b0;
    int   tick_base = 0;

    // Expected lamp words (phase p at [2p+1:2p])
    localparam logic [7:0] L_P0_GRN = 8'hA8;
    localparam logic [7:0] L_P0_YEL = 8'hA9;
    localparam logic [7:0] L_ALLRED = 8'hAA;
    localparam logic [7:0] L_P1_GRN = 8'hA2;
    localparam logic [7:0] L_P2_GRN = 8'h8A;
    localparam logic [7:0] L_P3_GRN = 8'h2A;
    localparam logic [7:0] L_P3_YEL = 8'h6A;

    traffic_phase_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .demand       (demand),
        .lights       (lights),
        .active_phase (active_phase),
        .phase_start  (phase_start),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Advance to #1 after edge k, pacing tick when the divided timebase is on
    task automatic goto(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            #1;
            if (tick_div) tick = ((edge_cnt + 1 - tick_base) % 5 == 0);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        demand   = 4'h0;
        tick     = 1'b1;
        tick_div = 1'b0;
        goto(edge_cnt + 2);
        check("rst_lights", 32'(lights), 32'(L_P0_GRN));
        check("rst_phase", 32'(active_phase), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_start", 32'(phase_start), 32'd0);
        rst_n = 1'b1;
        base  = edge_cnt;
    endtask

    // Scoreboard monitor plus the one-lamp-non-red invariant
    always @(negedge clk) begin
        int nonred;
        exp_t e;
        nonred = 0;
        for (int p = 0; p < 4; p++) if (lights[2*p +: 2] != 2'b10) nonred++;
        checks++;
        if (nonred > 1) begin
            errors++;
            $display("FAIL lamp_conflict: got lights=%0h required at most one non-red", lights);
        end
        if (phase_start === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_start: got phase_start=1 at edge %0d (phase %0d) required no pulse",
                         edge_cnt, active_phase);
            end else begin
                e = sb.pop_front();
                if (edge_cnt != e.edge_no || active_phase !== e.ph ||
                    lights !== e.lt || pending !== e.pd) begin
                    errors++;
                    $display("FAIL sb_start: got edge=%0d phase=%0d lights=%0h pending=%0h required edge=%0d phase=%0d lights=%0h pending=%0h",
                             edge_cnt, active_phase, lights, pending, e.edge_no, e.ph, e.lt, e.pd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: no demand, phase 0 rests in green, no phase_start
        goto(1);
        do_reset();
        goto(base + 100);
        check("t1_lights_mid", 32'(lights), 32'(L_P0_GRN));
        goto(base + 200);
        check("t1_lights_end", 32'(lights), 32'(L_P0_GRN));
        check("t1_phase_end", 32'(active_phase), 32'd0);

        // 2: one-cycle demand[2] pulse, full min-green sequence to phase 2
        do_reset();
        sb.push_back('{base + 16, 2'd2, L_P2_GRN, 4'h0});
        goto(base + 2);
        demand = 4'b0100;
        goto(base + 3);
        demand = 4'b0000;
        check("t2_pend_latched", 32'(pending), 32'h4);
        goto(base + 9);
        check("t2_last_green", 32'(lights), 32'(L_P0_GRN));
        goto(base + 10);
        check("t2_yellow", 32'(lights), 32'(L_P0_YEL));
        goto(base + 13);
        check("t2_last_yellow", 32'(lights), 32'(L_P0_YEL));
        goto(base + 14);
        check("t2_allred", 32'(lights), 32'(L_ALLRED));
        goto(base + 15);
        check("t2_allred_hold", 32'(lights), 32'(L_ALLRED));
        goto(base + 17);
        demand = 4'b0100;
        goto(base + 18);
        demand = 4'b0000;
        check("t2_no_self_pend", 32'(pending), 32'h0);

        // 3: demand[0] held keeps green until the max-green limit
        do_reset();
        sb.push_back('{base + 66, 2'd1, L_P1_GRN, 4'h1});
        sb.push_back('{base + 82, 2'd0, L_P0_GRN, 4'h0});
        demand = 4'b0011;
        goto(base + 1);
        demand = 4'b0001;
        goto(base + 59);
        check("t3_green_at_59", 32'(lights), 32'(L_P0_GRN));
        goto(base + 60);
        check("t3_yellow_at_60", 32'(lights), 32'(L_P0_YEL));
        goto(base + 66);
        demand = 4'b0000;
        goto(base + 90);

        // 4: from phase 2, pending 1 and 3 -> serve 3 then wrap to 1
        do_reset();
        sb.push_back('{base + 16, 2'd2, L_P2_GRN, 4'h0});
        sb.push_back('{base + 32, 2'd3, L_P3_GRN, 4'h2});
        sb.push_back('{base + 48, 2'd1, L_P1_GRN, 4'h0});
        demand = 4'b0100;
        goto(base + 1);
        demand = 4'b0000;
        goto(base + 16);
        demand = 4'b1010;
        goto(base + 17);
        demand = 4'b0000;
        check("t4_pend_two", 32'(pending), 32'hA);
        goto(base + 56);

        // 5: tick every 5th cycle, all durations stretch by five
        do_reset();
        tick_div  = 1'b1;
        tick_base = base;
        tick      = 1'b0;
        sb.push_back('{base + 80, 2'd2, L_P2_GRN, 4'h0});
        demand = 4'b0100;
        goto(base + 1);
        demand = 4'b0000;
        goto(base + 49);
        check("t5_green_49", 32'(lights), 32'(L_P0_GRN));
        goto(base + 50);
        check("t5_yellow_50", 32'(lights), 32'(L_P0_YEL));
        goto(base + 54);
        check("t5_yellow_hold_54", 32'(lights), 32'(L_P0_YEL));
        goto(base + 69);
        check("t5_yellow_69", 32'(lights), 32'(L_P0_YEL));
        goto(base + 70);
        check("t5_allred_70", 32'(lights), 32'(L_ALLRED));
        goto(base + 79);
        check("t5_allred_79", 32'(lights), 32'(L_ALLRED));
        goto(base + 85);
        tick_div = 1'b0;
        tick     = 1'b1;

        // 6: reset while phase 3 is yellow
        do_reset();
        sb.push_back('{base + 16, 2'd3, L_P3_GRN, 4'h0});
        demand = 4'b1000;
        goto(base + 1);
        demand = 4'b0000;
        goto(base + 16);
        demand = 4'b0011;
        goto(base + 17);
        demand = 4'b0000;
        goto(base + 27);
        check("t6_yellow_p3", 32'(lights), 32'(L_P3_YEL));
        check("t6_pend_before", 32'(pending), 32'h3);
        rst_n = 1'b0;
        goto(base + 28);
        check("t6_rst_lights", 32'(lights), 32'(L_P0_GRN));
        check("t6_rst_phase", 32'(active_phase), 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        check("t6_rst_start", 32'(phase_start), 32'd0);
        rst_n = 1'b1;
        goto(base + 60);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unserved expected starts required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_traffic_phase_controller
`default_nettype wire
